id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. It owns the IF/ID pipeline latch, the 16×32 architectural register file with its write-back port, the instruction-field and control decoder, and the condition-code check. Its outputs feed the ID/EX latch.

## Interface
- No parameters. Widths are fixed: 32-bit datapath, 4-bit register index.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-low reset.
- `freeze` in 1: hold the IF/ID latch (hazard stall).
- `flush` in 1: branch taken downstream; squash the latch contents.
- `if_pc` in 32: PC+4 from fetch.
- `if_instruction` in 32: fetched word.
- `wb_en` in 1: register write enable from write-back.
- `wb_dest` in 4: write index.
- `wb_value` in 32: write data.
- `status` in 4: NZCV flags, bit3=N.
- `pc` out 32: latched PC+4.
- `rn_val` out 32, `rm_val` out 32: register read data.
- `dest` out 4 (Rd), `src1` out 4 (Rn), `src2` out 4: Rm, or Rd when storing.
- `exe_cmd` out 4; `mem_r`, `mem_w`, `wb_en_out`, `s_out`, `b_out` out 1 each.
- `imm` out 1; `shift_operand` out 12; `signed_imm24` out 24.
- `two_src` out 1: `src2` is a real operand, for hazard detection.
- `valid` out 1: the latch holds a live instruction.

## Operation
- **IF/ID latch** (fields: pc, instr, valid). Priority order:
  - `!rst`: pc=0, instr=0, valid=0.
  - `flush`: pc=0, instr=0, valid=0. Flush beats freeze.
  - `freeze`: hold all fields.
  - Otherwise: load `if_pc`, `if_instruction`, valid=1.
- **Field extraction** from the latched instr:
  - cond[31:28], mode[27:26], imm[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], shift_operand[11:0], signed_imm24[23:0].
- **Decode for mode 00** (opcode → exe_cmd; wb_en_out=1 unless noted):
  - MOV 1101→0001; MVN 1111→1001; ADD 0100→0010; ADC 0101→0011; SUB 0010→0100; SBC 0110→0101.
  - AND 0000→0110; ORR 1100→0111; EOR 0001→1000.
  - CMP 1010→0100 and TST 1000→0110: wb_en_out=0.
  - s_out=S.
- **Decode for mode 01, opcode 0100**: exe_cmd=0010.
  - S=1 (LDR): mem_r=1, wb_en_out=1.
  - S=0 (STR): mem_w=1.
- **Decode for mode 10**: b_out=1, exe_cmd=0000.
- Any other mode or opcode decodes as NOP: all control outputs 0.
- **Condition check** on `status`:
  - EQ 0000, NE 0001, CS 0010, CC 0011, MI 0100, PL 0101, VS 0110, VC 0111.
  - HI 1000, LS 1001, GE 1010, LT 1011, GT 1100, LE 1101, AL 1110.
  - 1111 is treated as never.
  - If the condition fails or valid=0, force wb_en_out, mem_r, mem_w, s_out and b_out to 0. exe_cmd is unaffected.
- **Register file**:
  - Writes on the rising edge when wb_en=1; all 16 registers reset to 0.
  - Read ports are combinational. src2 = Rd when mem_w, else shift_operand[3:0].
  - Write bypass: if wb_en=1 and wb_dest equals a read index, that port returns wb_value in the same cycle.
- two_src = (imm==0) | mem_w.

## Timing
- Latch latency: fetch outputs sampled at edge n appear at the outputs during cycle n+1.
- All outputs are combinational from the latch, the register file and the inputs.
- After reset:
  - valid=0, pc=0.
  - Control outputs and exe_cmd are 0.
  - src1, src2 and dest are 0.
  - rn_val and rm_val are 0, unless bypass is active.
- Freeze held for k cycles keeps the outputs stable for k cycles. Register reads still reflect writes that land during the freeze.
- Flush and wb_en in the same cycle: both take effect; the write is never squashed.
- A write to register r at edge n is visible through the array from cycle n+1, and through bypass during cycle n.
- Reset asserted mid-stream clears the latch and every register at that edge. Writes in the reset cycle are dropped.

## Structure
- Shared package `arm_defs_pkg`:
  - cond-code constants, mode constants, opcode constants, exe_cmd constants.
  - NOP instruction constant (32'h0).
- Sub-module `register_file`: 16×32 array, two combinational read ports with write bypass, one synchronous write port, synchronous active-low reset.
- Decoder and condition check stay in `id_stage`.

## Test plan
- **Reset**: rst=0 for 2 cycles, then 1 with freeze=1 → valid=0, pc=0, wb_en_out=0, rn_val=0.
- **ADD decode**: load R2=7 and R3=9 via wb, then if_instruction=32'hE0821003 → exe_cmd=0010, src1=2, src2=3, dest=1, rn_val=7, rm_val=9, wb_en_out=1, two_src=1.
- **LDR decode**: 32'hE4910004 → mem_r=1, wb_en_out=1, exe_cmd=0010, imm=0, dest=0, src1=1.
- **Conditional branch**: 32'h0A000004 with status=4'b0000 → b_out=0. With status=4'b0100 → b_out=1, signed_imm24=24'h000004.
- **Bypass**: while decoding E0821003, apply wb_en=1, wb_dest=2, wb_value=32'h55 → rn_val=32'h55 that cycle and from the array afterwards.
- **Freeze/flush**: freeze=1 for 3 cycles → outputs held. Then flush=1 with freeze=1 → next cycle valid=0, instruction decodes as NOP, pc=0.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared encodings for the ARM-style pipeline: condition codes, instruction
// modes, opcodes, execute commands and the decoded control bundle.
package arm_defs_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    typedef enum logic [1:0] {
        MODE_ARITH  = 2'b00,
        MODE_MEM    = 2'b01,
        MODE_BRANCH = 2'b10
    } mode_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_LDR_STR = 4'b0100;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [3:0] exe_cmd;
        logic       mem_r;
        logic       mem_w;
        logic       wb_en;
        logic       s;
        logic       b;
    } ctrl_t;

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage output bundle towards the ID/EX latch.
interface id_stage_if;
    logic [31:0] pc;
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exe_cmd;
    logic        mem_r;
    logic        mem_w;
    logic        wb_en_out;
    logic        s_out;
    logic        b_out;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    logic        two_src;
    logic        valid;

    modport master (
        output pc, rn_val, rm_val, dest, src1, src2, exe_cmd, mem_r, mem_w,
               wb_en_out, s_out, b_out, imm, shift_operand, signed_imm24, two_src, valid
    );
    modport slave (
        input  pc, rn_val, rm_val, dest, src1, src2, exe_cmd, mem_r, mem_w,
               wb_en_out, s_out, b_out, imm, shift_operand, signed_imm24, two_src, valid
    );
endinterface

// File: rtl/register_file.sv
// 16x32 architectural register file: one synchronous write port and two
// combinational read ports that forward a same-cycle write.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  raddr1,
    input  logic [3:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        wen,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [16];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wen) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (wen && (waddr == raddr1)) ? wdata : regs[raddr1];
    assign rdata2 = (wen && (waddr == raddr2)) ? wdata : regs[raddr2];
endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID latch, register file, field/control decode
// and condition-code gating feeding the ID/EX latch.
module id_stage
    import arm_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic [3:0]  status,
    id_stage_if.master  id
);
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (!freeze) begin
            pc_q    <= if_pc;
            instr_q <= if_instruction;
            valid_q <= 1'b1;
        end
    end

    logic [3:0] cond;
    mode_e      mode;
    logic [3:0] opcode;
    logic       s_bit;
    logic [3:0] rn;
    logic [3:0] rd;

    assign cond   = instr_q[31:28];
    assign mode   = mode_e'(instr_q[27:26]);
    assign opcode = instr_q[24:21];
    assign s_bit  = instr_q[20];
    assign rn     = instr_q[19:16];
    assign rd     = instr_q[15:12];

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
        logic n, z, cy, v, r;
        {n, z, cy, v} = nzcv;
        case (c)
            COND_EQ: r = z;
            COND_NE: r = !z;
            COND_CS: r = cy;
            COND_CC: r = !cy;
            COND_MI: r = n;
            COND_PL: r = !n;
            COND_VS: r = v;
            COND_VC: r = !v;
            COND_HI: r = cy && !z;
            COND_LS: r = !cy || z;
            COND_GE: r = (n == v);
            COND_LT: r = (n != v);
            COND_GT: r = !z && (n == v);
            COND_LE: r = z || (n != v);
            COND_AL: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // An empty latch decodes as NOP so exe_cmd also reads 0 after reset/flush.
    ctrl_t dec;
    always_comb begin
        dec = '0;
        if (valid_q) begin
            case (mode)
                MODE_ARITH: begin
                    dec.wb_en = 1'b1;
                    dec.s     = s_bit;
                    case (opcode)
                        OP_MOV:  dec.exe_cmd = EXE_MOV;
                        OP_MVN:  dec.exe_cmd = EXE_MVN;
                        OP_ADD:  dec.exe_cmd = EXE_ADD;
                        OP_ADC:  dec.exe_cmd = EXE_ADC;
                        OP_SUB:  dec.exe_cmd = EXE_SUB;
                        OP_SBC:  dec.exe_cmd = EXE_SBC;
                        OP_AND:  dec.exe_cmd = EXE_AND;
                        OP_ORR:  dec.exe_cmd = EXE_ORR;
                        OP_EOR:  dec.exe_cmd = EXE_EOR;
                        OP_CMP:  begin dec.exe_cmd = EXE_SUB; dec.wb_en = 1'b0; end
                        OP_TST:  begin dec.exe_cmd = EXE_AND; dec.wb_en = 1'b0; end
                        default: dec = '0;
                    endcase
                end
                MODE_MEM: begin
                    if (opcode == OP_LDR_STR) begin
                        dec.exe_cmd = EXE_ADD;
                        dec.mem_r   = s_bit;
                        dec.wb_en   = s_bit;
                        dec.mem_w   = !s_bit;
                    end
                end
                MODE_BRANCH: begin
                    dec.b       = 1'b1;
                    dec.exe_cmd = EXE_NOP;
                end
                default: dec = '0;
            endcase
        end
    end

    logic exec_ok;
    assign exec_ok = valid_q && cond_pass(cond, status);

    assign id.exe_cmd   = dec.exe_cmd;
    assign id.mem_r     = dec.mem_r && exec_ok;
    assign id.mem_w     = dec.mem_w && exec_ok;
    assign id.wb_en_out = dec.wb_en && exec_ok;
    assign id.s_out     = dec.s && exec_ok;
    assign id.b_out     = dec.b && exec_ok;

    assign id.pc            = pc_q;
    assign id.valid         = valid_q;
    assign id.dest          = rd;
    assign id.src1          = rn;
    assign id.src2          = id.mem_w ? rd : instr_q[3:0];
    assign id.imm           = instr_q[25];
    assign id.shift_operand = instr_q[11:0];
    assign id.signed_imm24  = instr_q[23:0];
    assign id.two_src       = !instr_q[25] || id.mem_w;

    register_file u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rn),
        .raddr2 (id.src2),
        .rdata1 (id.rn_val),
        .rdata2 (id.rm_val),
        .wen    (wb_en),
        .waddr  (wb_dest),
        .wdata  (wb_value)
    );
endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a behavioural model of
// the IF/ID latch, register file and decode rules.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, freeze, flush, wb_en;
    logic [31:0] if_pc, if_instruction, wb_value;
    logic [3:0]  wb_dest, status;

    id_stage_if bus ();

    id_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .if_pc(if_pc), .if_instruction(if_instruction),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .status(status), .id(bus.master)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    logic [31:0] m_rf [16];

    // exe_cmd per data-processing opcode; -1 marks an undefined opcode
    int alu_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    logic [3:0]  e_exe, e_dest, e_src1, e_src2;
    logic        e_mr, e_mw, e_wbo, e_so, e_bo, e_two;
    logic [31:0] e_rn, e_rm;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        bit base [7];
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        base[0] = z;  base[1] = cy; base[2] = n; base[3] = v;
        base[4] = cy && !z; base[5] = (n == v); base[6] = !z && (n == v);
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        // conditions come in complementary pairs; odd codes negate the even one
        return c[0] ? !base[c[3:1]] : base[c[3:1]];
    endfunction

    task automatic compute_expected();
        logic [1:0] mode;
        logic [3:0] op;
        logic       sb;
        mode = m_instr[27:26]; op = m_instr[24:21]; sb = m_instr[20];
        e_exe = 0; e_mr = 0; e_mw = 0; e_wbo = 0; e_so = 0; e_bo = 0;
        if (m_valid) begin
            if (mode == 2'd0 && alu_cmd[op] >= 0) begin
                e_exe = 4'(alu_cmd[op]);
                e_wbo = !(op == 4'b1000 || op == 4'b1010);
                e_so  = sb;
            end else if (mode == 2'd1 && op == 4'd4) begin
                e_exe = 4'd2; e_mr = sb; e_wbo = sb; e_mw = !sb;
            end else if (mode == 2'd2) begin
                e_bo = 1'b1;
            end
        end
        if (!(m_valid && cond_ok(m_instr[31:28], status))) begin
            e_mr = 0; e_mw = 0; e_wbo = 0; e_so = 0; e_bo = 0;
        end
        e_src1 = m_instr[19:16];
        e_dest = m_instr[15:12];
        e_src2 = e_mw ? m_instr[15:12] : m_instr[3:0];
        e_rn   = (wb_en && wb_dest == e_src1) ? wb_value : m_rf[e_src1];
        e_rm   = (wb_en && wb_dest == e_src2) ? wb_value : m_rf[e_src2];
        e_two  = !m_instr[25] || e_mw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        compute_expected();
        chk({ctx, ".pc"},      bus.pc, m_pc);
        chk({ctx, ".valid"},   32'(bus.valid), 32'(m_valid));
        chk({ctx, ".exe_cmd"}, 32'(bus.exe_cmd), 32'(e_exe));
        chk({ctx, ".ctrl"},    32'({bus.mem_r, bus.mem_w, bus.wb_en_out, bus.s_out, bus.b_out}),
                               32'({e_mr, e_mw, e_wbo, e_so, e_bo}));
        chk({ctx, ".regs"},    32'({bus.dest, bus.src1, bus.src2}), 32'({e_dest, e_src1, e_src2}));
        chk({ctx, ".rn_val"},  bus.rn_val, e_rn);
        chk({ctx, ".rm_val"},  bus.rm_val, e_rm);
        chk({ctx, ".imm"},     32'(bus.imm), 32'(m_instr[25]));
        chk({ctx, ".shop"},    32'(bus.shift_operand), 32'(m_instr[11:0]));
        chk({ctx, ".imm24"},   32'(bus.signed_imm24), 32'(m_instr[23:0]));
        chk({ctx, ".two_src"}, 32'(bus.two_src), 32'(e_two));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_pc = 0; m_instr = 0; m_valid = 0;
            for (int i = 0; i < 16; i++) m_rf[i] = 0;
        end else begin
            if (wb_en) m_rf[wb_dest] = wb_value;
            if (flush) begin
                m_pc = 0; m_instr = 0; m_valid = 0;
            end else if (!freeze) begin
                m_pc = if_pc; m_instr = if_instruction; m_valid = 1'b1;
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[27:26] = 2'b00;
            1: begin w[27:26] = 2'b01; w[24:21] = 4'b0100; end
            2: w[27:26] = 2'b10;
            default: ;
        endcase
        if ($urandom_range(0, 2) == 0) w[31:28] = 4'hE;
        return w;
    endfunction

    initial begin
        m_pc = 0; m_instr = 0; m_valid = 0;
        for (int i = 0; i < 16; i++) m_rf[i] = 'x;
        rst = 0; freeze = 0; flush = 0; wb_en = 0; wb_dest = 0; wb_value = 0;
        if_pc = 32'h44; if_instruction = 32'hE0821003; status = 0;
        tick(); tick();

        rst = 1; freeze = 1;
        @(negedge clk);
        chk("rst.valid", 32'(bus.valid), 32'd0);
        chk("rst.pc", bus.pc, 32'd0);
        chk("rst.wb_en_out", 32'(bus.wb_en_out), 32'd0);
        chk("rst.rn_val", bus.rn_val, 32'd0);
        chk("rst.exe_cmd", 32'(bus.exe_cmd), 32'd0);
        check_all("rst");
        tick();

        wb_en = 1; wb_dest = 2; wb_value = 7; tick();
        wb_dest = 3; wb_value = 9; tick();
        wb_en = 0; freeze = 0; if_pc = 32'h104; if_instruction = 32'hE0821003;
        tick();
        @(negedge clk);
        chk("add.exe_cmd", 32'(bus.exe_cmd), 32'h2);
        chk("add.src1", 32'(bus.src1), 32'd2);
        chk("add.src2", 32'(bus.src2), 32'd3);
        chk("add.dest", 32'(bus.dest), 32'd1);
        chk("add.rn_val", bus.rn_val, 32'd7);
        chk("add.rm_val", bus.rm_val, 32'd9);
        chk("add.wb_en_out", 32'(bus.wb_en_out), 32'd1);
        chk("add.two_src", 32'(bus.two_src), 32'd1);
        chk("add.pc", bus.pc, 32'h104);
        check_all("add");

        freeze = 1; wb_en = 1; wb_dest = 2; wb_value = 32'h55;
        @(negedge clk);
        chk("byp.rn_now", bus.rn_val, 32'h55);
        check_all("byp");
        tick();
        wb_en = 0;
        @(negedge clk);
        chk("byp.rn_array", bus.rn_val, 32'h55);

        if_pc = 32'h200; if_instruction = 32'hE4910004;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            chk("frz.pc", bus.pc, 32'h104);
            chk("frz.exe_cmd", 32'(bus.exe_cmd), 32'h2);
            chk("frz.dest", 32'(bus.dest), 32'd1);
            check_all("frz");
        end

        flush = 1; tick(); flush = 0;
        @(negedge clk);
        chk("fl.valid", 32'(bus.valid), 32'd0);
        chk("fl.pc", bus.pc, 32'd0);
        chk("fl.exe_cmd", 32'(bus.exe_cmd), 32'd0);
        chk("fl.wb_en_out", 32'(bus.wb_en_out), 32'd0);
        check_all("fl");

        freeze = 0; tick();
        @(negedge clk);
        chk("ldr.mem_r", 32'(bus.mem_r), 32'd1);
        chk("ldr.wb_en_out", 32'(bus.wb_en_out), 32'd1);
        chk("ldr.exe_cmd", 32'(bus.exe_cmd), 32'h2);
        chk("ldr.imm", 32'(bus.imm), 32'd0);
        chk("ldr.dest", 32'(bus.dest), 32'd0);
        chk("ldr.src1", 32'(bus.src1), 32'd1);
        check_all("ldr");

        if_instruction = 32'h0A000004; status = 4'b0000; tick();
        @(negedge clk);
        chk("beq.fail", 32'(bus.b_out), 32'd0);
        check_all("beq0");
        status = 4'b0100;
        @(negedge clk);
        chk("beq.pass", 32'(bus.b_out), 32'd1);
        chk("beq.imm24", 32'(bus.signed_imm24), 32'h4);
        check_all("beq1");

        flush = 1; wb_en = 1; wb_dest = 5; wb_value = 32'hAB; tick();
        flush = 0; wb_en = 0; freeze = 1; if_instruction = 32'hE0821005; tick();
        freeze = 0; tick();
        @(negedge clk);
        chk("flwb.rm_val", bus.rm_val, 32'hAB);
        check_all("flwb");

        rst = 0; wb_en = 1; wb_dest = 2; wb_value = 32'h99; tick();
        rst = 1; wb_en = 0; freeze = 1;
        @(negedge clk);
        chk("mrst.valid", 32'(bus.valid), 32'd0);
        check_all("mrst0");
        freeze = 0; tick();
        @(negedge clk);
        chk("mrst.rn_val", bus.rn_val, 32'd0);
        chk("mrst.rm_val", bus.rm_val, 32'd0);
        check_all("mrst1");

        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) != 0);
            freeze   = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_dest  = 4'($urandom_range(0, 15));
            wb_value = $urandom;
            if_pc    = $urandom;
            if_instruction = rand_instr();
            status   = 4'($urandom_range(0, 15));
            @(negedge clk);
            check_all("rnd");
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
